// File: rtl/dac_serial_rx_if.sv
// DAC serial monitor bus: serial pins and readback address in, decoded frame state out.
// Purely combinational wiring; no handshake, the DAC line cannot be stalled.
interface dac_serial_rx_if #(
  parameter int WORD_BITS = 16,
  parameter int ERR_CNT_W = 8,
  parameter int CHAN_W    = 3,
  parameter int DATA_W    = 12
) ();
  logic                 i_ser_clk;
  logic                 i_nsync;
  logic                 i_din;
  logic [CHAN_W-1:0]    i_rd_chan;
  logic [WORD_BITS-1:0] o_word_out;
  logic                 o_word_valid;
  logic                 o_frame_error;
  logic [ERR_CNT_W-1:0] o_err_count;
  logic [WORD_BITS-1:0] o_ctrl_last;
  logic [DATA_W-1:0]    o_rd_data;

  modport slave (
    input  i_ser_clk, i_nsync, i_din, i_rd_chan,
    output o_word_out, o_word_valid, o_frame_error, o_err_count, o_ctrl_last, o_rd_data
  );

  modport master (
    output i_ser_clk, i_nsync, i_din, i_rd_chan,
    input  o_word_out, o_word_valid, o_frame_error, o_err_count, o_ctrl_last, o_rd_data
  );
endinterface

// File: rtl/dac_serial_rx.sv
// Deserialises 3-wire DAC frames, shadows per-channel codes and counts malformed frames.
// word_valid lands SYNC_STAGES+2 clk after the last falling ser_clk; passive monitor, no backpressure.
module dac_serial_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = 16,
  parameter int N_CHAN      = 8,
  parameter int ERR_CNT_W   = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  dac_serial_rx_if.slave  bus
);
  localparam int CHAN_W = $clog2(N_CHAN);
  localparam int DATA_W = WORD_BITS - 4;
  localparam int CNT_W  = $clog2(WORD_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_OVER} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_nsync_sync, r_din_sync;
  logic                   r_sclk_d, r_nsync_d;
  logic [WORD_BITS-1:0]   r_sr, r_word_out, r_ctrl_last;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_word_vld, r_frame_err;
  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic [DATA_W-1:0]      r_shadow [N_CHAN];
  logic [DATA_W-1:0]      r_rd_data;

  logic w_sclk_s, w_nsync_s, w_din_s;
  logic w_sclk_fall, w_nsync_fall, w_nsync_rise;
  logic w_shift, w_load, w_err, w_cnt_clr;

  assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
  assign w_nsync_s    = r_nsync_sync[SYNC_STAGES-1];
  assign w_din_s      = r_din_sync[SYNC_STAGES-1];
  assign w_sclk_fall  = r_sclk_d & ~w_sclk_s;
  assign w_nsync_fall = r_nsync_d & ~w_nsync_s;
  assign w_nsync_rise = ~r_nsync_d & w_nsync_s;

  // ser_clk resets high and nsync low so lines already idle or mid-frame at release raise no edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sclk_sync  <= '1;
      r_nsync_sync <= '0;
      r_din_sync   <= '0;
      r_sclk_d     <= 1'b1;
      r_nsync_d    <= 1'b0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], bus.i_ser_clk};
      r_nsync_sync <= {r_nsync_sync[SYNC_STAGES-2:0], bus.i_nsync};
      r_din_sync   <= {r_din_sync[SYNC_STAGES-2:0], bus.i_din};
      r_sclk_d     <= w_sclk_s;
      r_nsync_d    <= w_nsync_s;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_err       = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nsync_fall) begin
          w_state_nxt = S_SHIFT;
          w_cnt_clr   = 1'b1;
        end
      end
      S_SHIFT: begin
        // A full word is committed even if nsync rises in the same cycle.
        if (r_bit_cnt == LAST_BIT) begin
          w_load      = 1'b1;
          w_state_nxt = w_nsync_rise ? S_IDLE : S_DONE;
        end else if (w_nsync_rise) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_sclk_fall) begin
          w_shift = 1'b1;
        end
      end
      S_DONE: begin
        if (w_nsync_rise) begin
          w_state_nxt = S_IDLE;
        end else if (w_sclk_fall) begin
          w_err       = 1'b1;
          w_state_nxt = S_OVER;
        end
      end
      S_OVER: begin
        if (w_nsync_rise) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_word_out  <= '0;
      r_word_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
      r_ctrl_last <= '0;
      r_rd_data   <= '0;
      for (int i = 0; i < N_CHAN; i++) r_shadow[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_word_vld  <= w_load;
      r_frame_err <= w_err;
      r_rd_data   <= r_shadow[bus.i_rd_chan];
      if (w_cnt_clr) r_bit_cnt <= '0;
      else if (w_shift) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_shift) r_sr <= {r_sr[WORD_BITS-2:0], w_din_s};
      if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
      if (w_load) begin
        r_word_out <= r_sr;
        if (r_sr[WORD_BITS-1]) r_ctrl_last <= r_sr;
        else r_shadow[r_sr[WORD_BITS-2 -: CHAN_W]] <= r_sr[DATA_W-1:0];
      end
    end
  end

  assign bus.o_word_out    = r_word_out;
  assign bus.o_word_valid  = r_word_vld;
  assign bus.o_frame_error = r_frame_err;
  assign bus.o_err_count   = r_err_cnt;
  assign bus.o_ctrl_last   = r_ctrl_last;
  assign bus.o_rd_data     = r_rd_data;
endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed bench for dac_serial_rx: table of frames plus hand-written reset, coincidence and saturation cases.
module tb_dac_serial_rx;
  localparam int SYNC_STAGES = 2;

  typedef struct {
    logic [31:0] val;
    int          nbits;
    int          wv;
    int          fe;
    logic [15:0] word;
    logic [7:0]  err;
    logic [15:0] ctrl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wv_cnt = 0, fe_cnt = 0, wv_cyc = 0, fe_cyc = 0;
  logic [11:0] rd_at_wv = '0, rd_after = '0;
  bit   take_next = 1'b0;
  int   fall_cyc [32];

  dac_serial_rx_if #(.WORD_BITS(16), .ERR_CNT_W(8), .CHAN_W(3), .DATA_W(12)) bus ();

  dac_serial_rx #(.SYNC_STAGES(SYNC_STAGES), .WORD_BITS(16), .N_CHAN(8), .ERR_CNT_W(8)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (take_next) begin
      rd_after  = bus.o_rd_data;
      take_next = 1'b0;
    end
    if (bus.o_word_valid) begin
      wv_cnt++;
      wv_cyc    = cyc;
      rd_at_wv  = bus.o_rd_data;
      take_next = 1'b1;
    end
    if (bus.o_frame_error) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One bit at clk/8: data set while ser_clk is high, then the sampling falling edge.
  task automatic bit_out(input logic b, input int idx, input bit rise_with_fall);
    bus.i_din = b;
    repeat (4) @(negedge clk);
    if (rise_with_fall) bus.i_nsync = 1'b1;
    bus.i_ser_clk = 1'b0;
    if (idx < 32) fall_cyc[idx] = cyc;
    repeat (4) @(negedge clk);
    bus.i_ser_clk = 1'b1;
  endtask

  task automatic send(input logic [31:0] val, input int nbits, input bit coincide);
    @(negedge clk);
    bus.i_nsync = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--)
      bit_out(val[i], nbits - 1 - i, coincide && (i == 0));
    repeat (4) @(negedge clk);
    bus.i_nsync = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  vec_t        tbl [6];
  logic [11:0] shadow_m [8];
  int          wv0, fe0;

  initial begin
    tbl[0] = '{32'h3ABC,  16, 1, 0, 16'h3ABC, 8'd0, 16'h0000};
    tbl[1] = '{32'h8123,  16, 1, 0, 16'h8123, 8'd0, 16'h8123};
    tbl[2] = '{32'h2A5,   10, 0, 1, 16'h8123, 8'd1, 16'h8123};
    tbl[3] = '{32'h5FFFA, 20, 1, 1, 16'h5FFF, 8'd2, 16'h8123};
    tbl[4] = '{32'h7001,  16, 1, 0, 16'h7001, 8'd2, 16'h8123};
    tbl[5] = '{32'h0FFF,  16, 1, 0, 16'h0FFF, 8'd2, 16'h8123};
    for (int c = 0; c < 8; c++) shadow_m[c] = '0;

    bus.i_ser_clk = 1'b1;
    bus.i_nsync   = 1'b1;
    bus.i_din     = 1'b0;
    bus.i_rd_chan = 3'd0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    chk("reset word_out",    32'(bus.o_word_out), 0);
    chk("reset word_valid",  32'(bus.o_word_valid), 0);
    chk("reset frame_error", 32'(bus.o_frame_error), 0);
    chk("reset err_count",   32'(bus.o_err_count), 0);
    chk("reset ctrl_last",   32'(bus.o_ctrl_last), 0);
    chk("reset rd_data",     32'(bus.o_rd_data), 0);

    for (int v = 0; v < 6; v++) begin
      wv0 = wv_cnt;
      fe0 = fe_cnt;
      send(tbl[v].val, tbl[v].nbits, 1'b0);
      chk($sformatf("v%0d word_valid pulses", v), 32'(wv_cnt - wv0), 32'(tbl[v].wv));
      chk($sformatf("v%0d frame_error pulses", v), 32'(fe_cnt - fe0), 32'(tbl[v].fe));
      chk($sformatf("v%0d word_out", v), 32'(bus.o_word_out), 32'(tbl[v].word));
      chk($sformatf("v%0d err_count", v), 32'(bus.o_err_count), 32'(tbl[v].err));
      chk($sformatf("v%0d ctrl_last", v), 32'(bus.o_ctrl_last), 32'(tbl[v].ctrl));
      if (tbl[v].wv == 1) begin
        chk($sformatf("v%0d word_valid latency", v), 32'(wv_cyc - fall_cyc[15]), 32'(SYNC_STAGES + 2));
        if (tbl[v].word[15] == 1'b0) shadow_m[tbl[v].word[14:12]] = tbl[v].word[11:0];
      end
      if (tbl[v].nbits > 16)
        chk($sformatf("v%0d overrun error at 17th edge", v), 32'(fe_cyc - fall_cyc[16]), 32'(SYNC_STAGES + 1));
    end

    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.i_rd_chan = 3'(c);
      @(negedge clk);
      chk($sformatf("readback ch%0d", c), 32'(bus.o_rd_data), 32'(shadow_m[c]));
    end

    // Shadow write and read of the same channel in one cycle: old value first, new one next.
    @(negedge clk);
    bus.i_rd_chan = 3'd2;
    send(32'h2123, 16, 1'b0);
    chk("same-cycle read old", 32'(rd_at_wv), 32'h000);
    chk("same-cycle read new", 32'(rd_after), 32'h123);

    // Reset in the middle of a frame with nsync held low.
    wv0 = wv_cnt;
    fe0 = fe_cnt;
    @(negedge clk);
    bus.i_nsync = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) bit_out(1'b1, i, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 8; i < 16; i++) bit_out(1'b0, i, 1'b0);
    repeat (4) @(negedge clk);
    bus.i_nsync = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid-reset word_valid pulses",  32'(wv_cnt - wv0), 0);
    chk("mid-reset frame_error pulses", 32'(fe_cnt - fe0), 0);
    chk("mid-reset err_count",          32'(bus.o_err_count), 0);
    chk("mid-reset word_out",           32'(bus.o_word_out), 0);
    chk("mid-reset shadow cleared",     32'(bus.o_rd_data), 0);

    wv0 = wv_cnt;
    send(32'h1055, 16, 1'b0);
    chk("post-reset word_valid pulses", 32'(wv_cnt - wv0), 1);
    chk("post-reset word_out",          32'(bus.o_word_out), 32'h1055);
    @(negedge clk);
    bus.i_rd_chan = 3'd1;
    @(negedge clk);
    chk("post-reset readback ch1",      32'(bus.o_rd_data), 32'h055);

    // nsync rise coincident with the 16th falling edge is a short frame.
    wv0 = wv_cnt;
    fe0 = fe_cnt;
    send(32'h4321, 16, 1'b1);
    chk("coincident word_valid pulses",  32'(wv_cnt - wv0), 0);
    chk("coincident frame_error pulses", 32'(fe_cnt - fe0), 1);
    chk("coincident err_count",          32'(bus.o_err_count), 1);
    chk("coincident word_out",           32'(bus.o_word_out), 32'h1055);

    fe0 = fe_cnt;
    for (int n = 1; n <= 300; n++) begin
      send(32'h2, 2, 1'b0);
      if (n == 100) chk("err_count after 100 short", 32'(bus.o_err_count), 101);
      if (n == 254) chk("err_count reaches max", 32'(bus.o_err_count), 255);
    end
    chk("saturated err_count",        32'(bus.o_err_count), 255);
    chk("saturation frame_error pulses", 32'(fe_cnt - fe0), 300);
    chk("saturation word_out",        32'(bus.o_word_out), 32'h1055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
